// File: rtl/jtag_reg_arbiter.sv
// jtag_reg_arbiter: round-robin arbiter that lets NUM_REQ requesters write a register bank, with host-change detect.
// Optional macro JTAG_ARB_HOST_UPD_EN enables per-register host shadows and oHOST_UPD pulses.
module jtag_reg_arbiter #(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 16,
    parameter int NUM_REQ  = 4
) (
    input  logic                      iMAIN_CLK,
    input  logic                      iRST_N,
    input  logic [NUM_REQ-1:0]        iREQ,
    input  logic [NUM_REQ*4-1:0]      iREQ_ADDR,
    input  logic [NUM_REQ*WIDTH-1:0]  iREQ_DATA,
    output logic [NUM_REQ-1:0]        oGNT,
    output logic                      oERR,
    output logic                      oBUSY,
    output logic [NUM_REGS*WIDTH-1:0] oREG_DATA,
    input  logic [NUM_REGS*WIDTH-1:0] iHOST_DATA,
    output logic [NUM_REGS-1:0]       oHOST_UPD
);
    localparam int PW = $clog2(NUM_REQ);
    typedef enum logic [1:0] {IDLE, WRITE, ACK} state_t;
    state_t                    state_q, state_d;
    logic [PW-1:0]             ptr_q, ptr_d, idx_q, idx_d, win;
    logic                      found;
    logic [3:0]                addr_q, addr_d;
    logic [WIDTH-1:0]          data_q, data_d;
    logic [NUM_REGS*WIDTH-1:0] regs_q, regs_d;

    function automatic int wrap(input int v);
        return (v >= NUM_REQ) ? v - NUM_REQ : v;
    endfunction

    // first requesting index at or after the pointer, ascending with wrap
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && iREQ[wrap(int'(ptr_q) + i)]) begin
                found = 1'b1;
                win   = PW'(wrap(int'(ptr_q) + i));
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = data_q;
        regs_d  = regs_q;
        case (state_q)
            IDLE: if (found) begin
                state_d = WRITE;
                idx_d   = win;
                addr_d  = iREQ_ADDR[4*int'(win) +: 4];
                data_d  = iREQ_DATA[WIDTH*int'(win) +: WIDTH];
                ptr_d   = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
            end
            WRITE: begin
                state_d = ACK;
                for (int i = 0; i < NUM_REGS; i++)
                    if (addr_q == 4'(i)) regs_d[WIDTH*i +: WIDTH] = data_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iMAIN_CLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            regs_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            regs_q  <= regs_d;
        end
    end

    assign oBUSY     = state_q != IDLE;
    assign oGNT      = (state_q == ACK) ? NUM_REQ'(1) << idx_q : '0;
    assign oERR      = (state_q == ACK) && ({1'b0, addr_q} >= 5'(NUM_REGS));
    assign oREG_DATA = regs_q;

`ifdef JTAG_ARB_HOST_UPD_EN
    logic [NUM_REGS*WIDTH-1:0] shadow_q;
    logic [NUM_REGS-1:0]       upd_q, upd_d;

    always_comb begin
        upd_d = '0;
        for (int i = 0; i < NUM_REGS; i++)
            upd_d[i] = iHOST_DATA[WIDTH*i +: WIDTH] != shadow_q[WIDTH*i +: WIDTH];
    end

    always_ff @(posedge iMAIN_CLK or negedge iRST_N) begin
        if (!iRST_N) begin
            shadow_q <= '0;
            upd_q    <= '0;
        end else begin
            shadow_q <= iHOST_DATA;
            upd_q    <= upd_d;
        end
    end

    assign oHOST_UPD = upd_q;
`else
    logic unused_host;
    assign unused_host = ^iHOST_DATA;
    assign oHOST_UPD   = '0;
`endif
endmodule

// File: doc/jtag_reg_arbiter.md
JTAG_REG_ARBITER -- requirements
Module: jtag_reg_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the register width in bits.
REQ-002 Parameter NUM_REGS, default 16, range 1..16, SHALL set the number of bank registers.
REQ-003 Parameter NUM_REQ, default 4, range 2..8, SHALL set the number of write requesters.
REQ-004 iMAIN_CLK  in  1  SHALL be the single clock; all logic is rising-edge.
REQ-005 iRST_N  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 iREQ  in  NUM_REQ  SHALL carry the per-requester write-request levels.
REQ-007 iREQ_ADDR  in  NUM_REQ*4  SHALL carry the target register index, 4 bits per requester, requester k at [4k+3:4k].
REQ-008 iREQ_DATA  in  NUM_REQ*WIDTH  SHALL carry the write data, WIDTH bits per requester, packed the same way.
REQ-009 oGNT  out  NUM_REQ  SHALL carry a one-cycle, one-hot completion pulse per requester.
REQ-010 oERR  out  1  SHALL pulse with oGNT when the granted address is >= NUM_REGS.
REQ-011 oBUSY  out  1  SHALL be high whenever the FSM is not in IDLE.
REQ-012 oREG_DATA  out  NUM_REGS*WIDTH  SHALL be the register values that drive the bank's host-readable inputs (register i at [WIDTH*i+WIDTH-1:WIDTH*i]).
REQ-013 iHOST_DATA  in  NUM_REGS*WIDTH  SHALL be the host-written bank outputs, already synchronous to iMAIN_CLK.
REQ-014 oHOST_UPD  out  NUM_REGS  SHALL carry the per-register host-change pulses.

Function
REQ-015 FSM states SHALL be IDLE, WRITE and ACK; every transition SHALL occur on a rising edge.
REQ-016 IDLE: when any iREQ bit is high, the FSM SHALL pick a winner round-robin, latch its index, address and data, and go to WRITE; otherwise it SHALL stay in IDLE.
REQ-017 Round-robin: the search SHALL start at pointer p, ascending modulo NUM_REQ; after granting k, p SHALL become (k+1) mod NUM_REQ.
REQ-018 WRITE: if the latched address is < NUM_REGS, that oREG_DATA slot SHALL take the latched data; the FSM SHALL then go to ACK unconditionally.
REQ-019 ACK: oGNT[k] SHALL be high for exactly this one cycle (and oERR too if the address was invalid); the FSM SHALL then return to IDLE.
REQ-020 Latency: with iREQ sampled at edge t, oREG_DATA SHALL update and oGNT SHALL assert after edge t+1, and oGNT SHALL deassert after edge t+2.
REQ-021 Requester inputs SHALL be sampled only at the IDLE decision edge; changes to iREQ, address or data during WRITE/ACK SHALL NOT affect the transaction in flight.
REQ-022 A requester still asserting iREQ in IDLE after its oGNT SHALL be treated as a new request, subject to round-robin.
REQ-023 Invalid address (>= NUM_REGS): no register SHALL change; oGNT and oERR SHALL pulse together.
REQ-024 Sustained back-to-back requests SHALL give at most one grant per 3 cycles, and every active requester SHALL be granted within NUM_REQ grants.
REQ-025 Unwritten oREG_DATA slots SHALL hold their value indefinitely.

Reset
REQ-026 Asserting iRST_N low SHALL immediately set the following: FSM to IDLE; p to 0; all oREG_DATA to 0; oGNT, oERR, oBUSY and oHOST_UPD to 0; host shadows to 0.
REQ-027 A reset during WRITE or ACK SHALL discard the transaction: no oGNT, and a register write not yet committed SHALL be lost.
REQ-028 Release of iRST_N SHALL take effect at the next rising edge, with the FSM in IDLE.

Configuration
REQ-029 With macro JTAG_ARB_HOST_UPD_EN defined, each register i SHALL keep a shadow of iHOST_DATA[i], updated every cycle, and oHOST_UPD[i] SHALL pulse one cycle, one cycle after iHOST_DATA[i] differs from its shadow.
REQ-030 With JTAG_ARB_HOST_UPD_EN defined, a nonzero iHOST_DATA value present at reset release SHALL produce one pulse.
REQ-031 Without JTAG_ARB_HOST_UPD_EN, no shadow registers SHALL exist and oHOST_UPD SHALL be tied to 0.

Verification
REQ-032 Reset, then requester 0 writes address 3 with 0xDEADBEEF -> oREG_DATA[3]=0xDEADBEEF and oGNT=0001 two cycles after the request edge, oBUSY high for 2 cycles.
REQ-033 All 4 requesters held high continuously from reset -> grant order 0,1,2,3,0 with oGNT pulses exactly 3 cycles apart.
REQ-034 NUM_REGS=12, requester 2 writes address 14 -> oGNT=0100 and oERR=1 in the same cycle, all oREG_DATA unchanged.
REQ-035 iRST_N pulsed low during WRITE of 0x12345678 to address 5 -> oREG_DATA[5]=0, no oGNT pulse, FSM in IDLE.
REQ-036 Macro defined: iHOST_DATA[7] changes 0->0x55 -> a single oHOST_UPD[7] pulse on the next cycle; macro undefined -> oHOST_UPD stays 0.
REQ-037 Requester 1 changes its address and data during WRITE -> the originally latched values are written.
